simd_muland_unit: RTL and testbench

SIMD_MULAND_UNIT -- requirements
Module: simd_muland

---
 rtl/simd_muland_unit.sv | 138 +++++++++++++
 tb/tb_simd_muland_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/simd_muland_unit.sv
// Lane-partitioned SIMD multiplier / AND unit. Each 256-bit slice is an independent
// 9-stage pipeline built from a masked 8x8 array of 32x32 partial products.

module simd_muland_blk (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [255:0] x_i,
    input  logic [255:0] y_i,
    input  logic [2:0]   mode_i,
    input  logic [2:0]   width_i,
    output logic [255:0] ps_o,
    output logic [255:0] sc_o
);
    // lm is the lane size in 32-bit words minus one (0,1,3,7); op = {bool, arith}
    logic [255:0]           x0_d, x0_q, y0_d, y0_q;
    logic [1:0]             op0_d, op0_q;
    logic [2:0]             lm0_d, lm0_q, lm1_q, lm2_q, lm3_q, lm4_q, lm5_q;
    logic [63:0][63:0]      pp_d, pp_q;
    logic [13:0][66:0]      dsum_d, dsum_q;
    logic [63:0]            dtop_d, dtop_q;
    logic [2:0][511:0]      row_d, row_q;
    logic [511:0]           r01_d, r01_q, r2_d, r2_q, acc_d, acc_q;
    logic [255:0]           ps6_d, ps6_q, sc6_d, sc6_q, ps7_d, ps7_q, sc7_d, sc7_q;
    logic [255:0]           ps8_d, ps8_q, sc8_d, sc8_q;

    always_comb begin
        x0_d  = x_i;
        y0_d  = y_i;
        op0_d = {mode_i == 3'b010, mode_i == 3'b100};
        lm0_d = ((mode_i == 3'b100) && (width_i inside {3'b001, 3'b011, 3'b111})) ? width_i : 3'b000;
    end

    // Boolean mode rides the array: x&y word w lands in pp(w,w), i.e. product word 2w.
    always_comb begin
        pp_d = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (op0_q[0] && (((3'(i) ^ 3'(j)) & ~lm0_q) == 3'b000))
                    pp_d[i*8+j] = 64'(x0_q[32*i +: 32]) * 64'(y0_q[32*j +: 32]);
                else if (op0_q[1] && (i == j))
                    pp_d[i*8+j] = {32'b0, x0_q[32*i +: 32] & y0_q[32*i +: 32]};
            end
        end
    end

    // pp(i,j) sits at bit 32*(i+j) regardless of lane width, so one sum serves all widths.
    always_comb begin
        dsum_d = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (i + j < 14)
                    dsum_d[i+j] = dsum_d[i+j] + 67'(pp_q[i*8+j]);
        dtop_d = pp_q[63];
    end

    // Diagonals three apart are 96 bits apart, so they pack into a row without overlap.
    always_comb begin
        row_d = '0;
        for (int d = 0; d < 14; d++)
            row_d[d % 3][32*d +: 67] = dsum_q[d];
        row_d[2][448 +: 64] = dtop_q;
        r01_d = row_q[0] + row_q[1];
        r2_d  = row_q[2];
        acc_d = r01_q + r2_q;
    end

    always_comb begin
        logic [2:0] wv, o;
        logic [3:0] pidx, sidx;
        ps6_d = '0;
        sc6_d = '0;
        for (int w = 0; w < 8; w++) begin
            wv   = 3'(w);
            o    = wv & lm5_q;
            pidx = {wv, 1'b0} - {1'b0, o};
            sidx = pidx + {1'b0, lm5_q} + 4'd1;
            ps6_d[32*w +: 32] = acc_q[{pidx, 5'b0} +: 32];
            sc6_d[32*w +: 32] = acc_q[{sidx, 5'b0} +: 32];
        end
        ps7_d = ps6_q;
        sc7_d = sc6_q;
        ps8_d = ps7_q;
        sc8_d = sc7_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x0_q <= '0; y0_q <= '0; op0_q <= '0; lm0_q <= '0;
            pp_q <= '0; lm1_q <= '0;
            dsum_q <= '0; dtop_q <= '0; lm2_q <= '0;
            row_q <= '0; lm3_q <= '0;
            r01_q <= '0; r2_q <= '0; lm4_q <= '0;
            acc_q <= '0; lm5_q <= '0;
            ps6_q <= '0; sc6_q <= '0;
            ps7_q <= '0; sc7_q <= '0;
            ps8_q <= '0; sc8_q <= '0;
        end else begin
            x0_q <= x0_d; y0_q <= y0_d; op0_q <= op0_d; lm0_q <= lm0_d;
            pp_q <= pp_d; lm1_q <= lm0_q;
            dsum_q <= dsum_d; dtop_q <= dtop_d; lm2_q <= lm1_q;
            row_q <= row_d; lm3_q <= lm2_q;
            r01_q <= r01_d; r2_q <= r2_d; lm4_q <= lm3_q;
            acc_q <= acc_d; lm5_q <= lm4_q;
            ps6_q <= ps6_d; sc6_q <= sc6_d;
            ps7_q <= ps7_d; sc7_q <= sc7_d;
            ps8_q <= ps8_d; sc8_q <= sc8_d;
        end
    end

    assign ps_o = ps8_q;
    assign sc_o = sc8_q;
endmodule

module simd_muland_unit #(
    parameter int DW = 256
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] x_i,
    input  logic [DW-1:0] y_i,
    input  logic [2:0]    mode_i,
    input  logic [2:0]    width_i,
    output logic [DW-1:0] ps_o,
    output logic [DW-1:0] sc_o
);
    localparam int NB = DW / 256;

    simd_muland_blk u_blk [NB-1:0] (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .x_i     (x_i),
        .y_i     (y_i),
        .mode_i  (mode_i),
        .width_i (width_i),
        .ps_o    (ps_o),
        .sc_o    (sc_o)
    );
endmodule

// File: tb/tb_simd_muland_unit.sv
// Self-checking bench for simd_muland_unit: directed vectors, random streaming, mid-stream reset.
// Expected results come from a lane-by-lane arithmetic model delayed through a queue.

module tb_simd_muland_unit;
    localparam int DW  = 512;
    localparam int LAT = 9;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [DW-1:0] x_i = '0, y_i = '0;
    logic [2:0]    mode_i = '0, width_i = '0;
    logic [DW-1:0] ps_o, sc_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [2*DW-1:0] expq[$];

    always #5 clk_i = ~clk_i;

    simd_muland_unit #(.DW(DW)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .x_i     (x_i),
        .y_i     (y_i),
        .mode_i  (mode_i),
        .width_i (width_i),
        .ps_o    (ps_o),
        .sc_o    (sc_o)
    );

    function automatic logic [2*DW-1:0] model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                              input logic [2:0] mode, input logic [2:0] width);
        int w;
        logic [DW-1:0] ps, sc;
        logic [255:0] msk, xl, yl;
        logic [511:0] p;
        ps = '0;
        sc = '0;
        case (width)
            3'b001:  w = 64;
            3'b011:  w = 128;
            3'b111:  w = 256;
            default: w = 32;
        endcase
        msk = (w == 256) ? '1 : ((256'(1) << w) - 256'(1));
        if (mode == 3'b100) begin
            for (int k = 0; k < DW / w; k++) begin
                xl = 256'(x >> (k * w)) & msk;
                yl = 256'(y >> (k * w)) & msk;
                p  = 512'(xl) * 512'(yl);
                ps = ps | (DW'(256'(p) & msk) << (k * w));
                sc = sc | (DW'(256'(p >> w) & msk) << (k * w));
            end
        end else if (mode == 3'b010) begin
            ps = x & y;
        end
        return {sc, ps};
    endfunction

    function automatic logic [DW-1:0] rep(input logic [255:0] lane, input int w);
        logic [DW-1:0] v = '0;
        for (int k = 0; k < DW / w; k++)
            v = v | (DW'(lane) << (k * w));
        return v;
    endfunction

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++)
            v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Check the result due now, then drive the next operation and queue its expectation.
    task automatic step(input logic [DW-1:0] x, input logic [DW-1:0] y,
                        input logic [2:0] mode, input logic [2:0] width);
        logic [2*DW-1:0] e;
        @(negedge clk_i);
        e = expq.pop_front();
        check("ps", ps_o, e[DW-1:0]);
        check("sc", sc_o, e[2*DW-1:DW]);
        x_i = x; y_i = y; mode_i = mode; width_i = width;
        expq.push_back(model(x, y, mode, width));
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        x_i = '0; y_i = '0; mode_i = '0; width_i = '0;
        #1;
        check("rst_ps_now", ps_o, '0);
        check("rst_sc_now", sc_o, '0);
        repeat (2) begin
            @(negedge clk_i);
            check("rst_ps_hold", ps_o, '0);
            check("rst_sc_hold", sc_o, '0);
        end
        rst_i = 1'b0;
        expq.delete();
        repeat (LAT) expq.push_back('0);
    endtask

    task automatic rand_step();
        int r;
        logic [2:0] m;
        r = $urandom_range(0, 9);
        if (r < 5)      m = 3'b100;
        else if (r < 8) m = 3'b010;
        else            m = 3'($urandom);
        step(rnd(), rnd(), m, 3'($urandom));
    endtask

    initial begin
        logic [255:0] lane;
        do_reset();

        step('1, rep(256'd2, 32), 3'b100, 3'b000);
        step(rep({1'b1, 255'b0}, 256), rep(256'd2, 256), 3'b100, 3'b111);
        step('1, '1, 3'b100, 3'b111);
        lane = 256'h8000_0000_0000_0001;
        step(rep(lane, 64), rep(256'd3, 64), 3'b100, 3'b001);
        lane = (256'(1) << 127) + 256'd1;
        step(rep(lane, 128), rep(256'd3, 128), 3'b100, 3'b011);
        step('1, {(DW/8){8'hA5}}, 3'b010, 3'($urandom));
        step('1, {(DW/8){8'hA5}}, 3'b010, 3'b111);
        step('1, '1, 3'b001, 3'b000);
        step('1, '1, 3'b100, 3'b110);
        step(rnd(), rnd(), 3'b100, 3'b010);

        repeat (200) rand_step();

        do_reset();
        step(rnd(), rnd(), 3'b100, 3'b111);
        repeat (100) rand_step();
        repeat (LAT) step('0, '0, 3'b000, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
